// File: rtl/axis_wrr_arbiter_if.sv
// axis_wrr_arbiter_if
//   Stream bundle around the weighted round-robin arbiter: NUM_CHAN packed
//   slave channels on the fan-in side and one merged master stream on the
//   fan-out side.
// Modports
//   slave  : arbiter view of the per-channel inputs (tvalid/tdata/tlast in, tready out)
//   master : arbiter view of the merged output (tvalid/tdata/tlast/tuser out, tready in)
// Both modports of one instance are normally connected to the same arbiter.
interface axis_wrr_arbiter_if #(
    parameter int unsigned NUM_CHAN   = 6,
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CW         = 3
);
    logic [NUM_CHAN-1:0]            s_axis_tvalid;
    logic [NUM_CHAN-1:0]            s_axis_tready;
    logic [NUM_CHAN*DATA_WIDTH-1:0] s_axis_tdata;
    logic [NUM_CHAN-1:0]            s_axis_tlast;

    logic                           m_axis_tvalid;
    logic                           m_axis_tready;
    logic [DATA_WIDTH-1:0]          m_axis_tdata;
    logic                           m_axis_tlast;
    logic [CW-1:0]                  m_axis_tuser;

    modport slave (
        input  s_axis_tvalid,
        input  s_axis_tdata,
        input  s_axis_tlast,
        output s_axis_tready
    );

    modport master (
        output m_axis_tvalid,
        output m_axis_tdata,
        output m_axis_tlast,
        output m_axis_tuser,
        input  m_axis_tready
    );
endinterface

// File: rtl/axis_wrr_arbiter.sv
// axis_wrr_arbiter
//   Weighted round-robin scheduler sharing one AXI-stream master among
//   NUM_CHAN slave streams. A grant lasts for cfg_weight packets (tlast mode)
//   or beats (beat mode), then rotates to the next requester above the last
//   grantee. Output data path is fully registered.
// Ports
//   axis_clk    : clock
//   axis_rstn   : asynchronous active-low reset
//   s_axis      : per-channel slave streams (slave modport)
//   m_axis      : merged master stream, tuser = source channel (master modport)
//   cfg_enable  : per-channel arbitration mask, looked at only while idle
//   cfg_weight  : packets/beats per grant per channel, 0 behaves as 1
//   arb_grant   : one-hot current grant, 0 while idle
//   arb_busy    : high while a grant is held
module axis_wrr_arbiter #(
    parameter int unsigned NUM_CHAN       = 6,
    parameter int unsigned DATA_WIDTH     = 256,
    parameter int unsigned WEIGHT_WIDTH   = 4,
    parameter bit          USE_AXIS_TLAST = 1'b1,
    localparam int unsigned CW            = $clog2(NUM_CHAN)
) (
    input  logic                           axis_clk,
    input  logic                           axis_rstn,
    axis_wrr_arbiter_if.slave              s_axis,
    axis_wrr_arbiter_if.master             m_axis,
    input  logic [NUM_CHAN-1:0]            cfg_enable,
    input  logic [NUM_CHAN*WEIGHT_WIDTH-1:0] cfg_weight,
    output logic [NUM_CHAN-1:0]            arb_grant,
    output logic                           arb_busy
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e                  state_q, state_d;
    logic [NUM_CHAN-1:0]     grant_q, grant_d;
    logic [CW-1:0]           gidx_q, gidx_d;
    logic [CW-1:0]           ptr_q, ptr_d;
    logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
    logic [WEIGHT_WIDTH-1:0] weff_q, weff_d;

    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic [CW-1:0]           out_user_q, out_user_d;

    logic [NUM_CHAN-1:0]     req;
    logic [NUM_CHAN-1:0]     above_ptr;
    logic [NUM_CHAN-1:0]     req_hi;
    logic [NUM_CHAN-1:0]     req_pick;
    logic [CW-1:0]           sel_idx;
    logic [WEIGHT_WIDTH-1:0] sel_weight;

    logic                    g_valid;
    logic                    g_last;
    logic [DATA_WIDTH-1:0]   g_data;
    logic                    out_free;
    logic                    accept;
    logic                    count_ev;
    logic                    release_grant;
    logic [WEIGHT_WIDTH-1:0] cnt_inc;

    assign req = s_axis.s_axis_tvalid & cfg_enable;

    // Rotating priority: requesters strictly above ptr win first; if none,
    // wrap around to the lowest requester overall.
    always_comb begin
        above_ptr = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            above_ptr[i] = (CW'(i) > ptr_q);
        end
        req_hi   = req & above_ptr;
        req_pick = (req_hi != '0) ? req_hi : req;
        sel_idx  = '0;
        for (int i = NUM_CHAN - 1; i >= 0; i--) begin
            if (req_pick[i]) begin
                sel_idx = CW'(i);
            end
        end
        sel_weight = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            if (sel_idx == CW'(i)) begin
                sel_weight = cfg_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    // Granted-channel mux, AND-OR over the one-hot grant.
    always_comb begin
        g_valid = |(s_axis.s_axis_tvalid & grant_q);
        g_last  = |(s_axis.s_axis_tlast & grant_q);
        g_data  = '0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            g_data = g_data | (s_axis.s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH]
                               & {DATA_WIDTH{grant_q[i]}});
        end
    end

    assign out_free = ~out_valid_q | m_axis.m_axis_tready;
    assign accept   = (state_q == StGrant) & g_valid & out_free;
    assign count_ev = accept & (g_last | ~USE_AXIS_TLAST);
    assign cnt_inc  = cnt_q + 1'b1;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        gidx_d        = gidx_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        weff_d        = weff_q;
        release_grant = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req != '0) begin
                    state_d = StGrant;
                    for (int i = 0; i < NUM_CHAN; i++) begin
                        grant_d[i] = (sel_idx == CW'(i));
                    end
                    gidx_d = sel_idx;
                    cnt_d  = '0;
                    weff_d = (sel_weight == '0) ? WEIGHT_WIDTH'(1) : sel_weight;
                end
            end
            StGrant: begin
                // cnt never wraps: release fires at cnt+1 == weff.
                if (count_ev) begin
                    if (cnt_inc == weff_q) begin
                        release_grant = 1'b1;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                // Beat mode hands the port on as soon as the grantee goes idle.
                if (!USE_AXIS_TLAST && !g_valid) begin
                    release_grant = 1'b1;
                end
                if (release_grant) begin
                    state_d = StIdle;
                    grant_d = '0;
                    ptr_d   = gidx_q;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_user_d  = out_user_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = g_data;
            out_last_d  = USE_AXIS_TLAST ? g_last : 1'b0;
            out_user_d  = gidx_q;
        end else if (m_axis.m_axis_tready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge axis_clk or negedge axis_rstn) begin
        if (!axis_rstn) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            gidx_q      <= '0;
            ptr_q       <= CW'(NUM_CHAN - 1);
            cnt_q       <= '0;
            weff_q      <= WEIGHT_WIDTH'(1);
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_user_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            weff_q      <= weff_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_user_q  <= out_user_d;
        end
    end

    assign s_axis.s_axis_tready = (state_q == StGrant && out_free) ? grant_q : '0;

    assign m_axis.m_axis_tvalid = out_valid_q;
    assign m_axis.m_axis_tdata  = out_data_q;
    assign m_axis.m_axis_tlast  = out_last_q;
    assign m_axis.m_axis_tuser  = out_user_q;

    assign arb_grant = grant_q;
    assign arb_busy  = (state_q == StGrant);

endmodule

// File: tb/tb_axis_wrr_arbiter.sv
// Bench for axis_wrr_arbiter: one packet-mode and one beat-mode instance
// driven by random AXI-stream sources, compared every cycle against a
// rule-level model of the grant rotation and an expected-beat queue.
module tb_axis_wrr_arbiter;
    localparam int unsigned NUM_CHAN     = 6;
    localparam int unsigned DATA_WIDTH   = 32;
    localparam int unsigned WEIGHT_WIDTH = 4;
    localparam int unsigned CW           = $clog2(NUM_CHAN);
    localparam int unsigned ND           = 2;  // 0: packet mode, 1: beat mode

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
        logic [CW-1:0]         user;
    } beat_t;

    logic axis_clk;
    logic axis_rstn;
    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Stimulus
    logic [NUM_CHAN-1:0]              src_valid  [ND];
    logic [NUM_CHAN*DATA_WIDTH-1:0]   src_tdata  [ND];
    logic [NUM_CHAN-1:0]              src_last   [ND];
    logic                             mready     [ND];
    logic [NUM_CHAN-1:0]              cfg_enable [ND];
    logic [NUM_CHAN*WEIGHT_WIDTH-1:0] cfg_weight [ND];

    // Observed
    logic [NUM_CHAN-1:0]   o_sready [ND];
    logic [NUM_CHAN-1:0]   o_grant  [ND];
    logic                  o_busy   [ND];
    logic                  o_mvalid [ND];
    logic [DATA_WIDTH-1:0] o_mdata  [ND];
    logic                  o_mlast  [ND];
    logic [CW-1:0]         o_muser  [ND];

    axis_wrr_arbiter_if #(.NUM_CHAN(NUM_CHAN), .DATA_WIDTH(DATA_WIDTH), .CW(CW)) bus_pkt ();
    axis_wrr_arbiter_if #(.NUM_CHAN(NUM_CHAN), .DATA_WIDTH(DATA_WIDTH), .CW(CW)) bus_beat ();

    assign bus_pkt.s_axis_tvalid  = src_valid[0];
    assign bus_pkt.s_axis_tdata   = src_tdata[0];
    assign bus_pkt.s_axis_tlast   = src_last[0];
    assign bus_pkt.m_axis_tready  = mready[0];
    assign bus_beat.s_axis_tvalid = src_valid[1];
    assign bus_beat.s_axis_tdata  = src_tdata[1];
    assign bus_beat.s_axis_tlast  = src_last[1];
    assign bus_beat.m_axis_tready = mready[1];

    assign o_sready[0] = bus_pkt.s_axis_tready;
    assign o_mvalid[0] = bus_pkt.m_axis_tvalid;
    assign o_mdata[0]  = bus_pkt.m_axis_tdata;
    assign o_mlast[0]  = bus_pkt.m_axis_tlast;
    assign o_muser[0]  = bus_pkt.m_axis_tuser;
    assign o_sready[1] = bus_beat.s_axis_tready;
    assign o_mvalid[1] = bus_beat.m_axis_tvalid;
    assign o_mdata[1]  = bus_beat.m_axis_tdata;
    assign o_mlast[1]  = bus_beat.m_axis_tlast;
    assign o_muser[1]  = bus_beat.m_axis_tuser;

    axis_wrr_arbiter #(
        .NUM_CHAN(NUM_CHAN), .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .USE_AXIS_TLAST(1'b1)
    ) u_dut_pkt (
        .axis_clk   (axis_clk),
        .axis_rstn  (axis_rstn),
        .s_axis     (bus_pkt),
        .m_axis     (bus_pkt),
        .cfg_enable (cfg_enable[0]),
        .cfg_weight (cfg_weight[0]),
        .arb_grant  (o_grant[0]),
        .arb_busy   (o_busy[0])
    );

    axis_wrr_arbiter #(
        .NUM_CHAN(NUM_CHAN), .DATA_WIDTH(DATA_WIDTH), .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .USE_AXIS_TLAST(1'b0)
    ) u_dut_beat (
        .axis_clk   (axis_clk),
        .axis_rstn  (axis_rstn),
        .s_axis     (bus_beat),
        .m_axis     (bus_beat),
        .cfg_enable (cfg_enable[1]),
        .cfg_weight (cfg_weight[1]),
        .arb_grant  (o_grant[1]),
        .arb_busy   (o_busy[1])
    );

    // Reference model: who holds the port, how many packets/beats remain,
    // where rotation resumes, and which beats must appear on the output.
    bit          m_busy [ND];
    int unsigned m_g    [ND];
    int unsigned m_left [ND];
    int unsigned m_ptr  [ND];
    bit          m_ov   [ND];
    beat_t       exp_q  [ND][$];

    // Source state
    int unsigned         pkt_left   [ND][NUM_CHAN];
    int unsigned         seq        [ND][NUM_CHAN];
    logic [NUM_CHAN-1:0] hs         [ND];
    int unsigned         stall_left [ND];

    int unsigned p_valid, p_ready, p_stall, p_cfg;
    bit          one_beat;
    bit          rec_on;
    int unsigned rec_user [$];

    int unsigned n_checks;
    int unsigned n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic init_sources();
        for (int d = 0; d < ND; d++) begin
            src_valid[d]  = '0;
            src_tdata[d]  = '0;
            src_last[d]   = '0;
            mready[d]     = 1'b0;
            hs[d]         = '0;
            stall_left[d] = 0;
            for (int c = 0; c < NUM_CHAN; c++) begin
                pkt_left[d][c] = 1;
            end
        end
    endtask

    task automatic reset_model();
        for (int d = 0; d < ND; d++) begin
            m_busy[d] = 1'b0;
            m_g[d]    = 0;
            m_left[d] = 0;
            m_ptr[d]  = NUM_CHAN - 1;
            m_ov[d]   = 1'b0;
            exp_q[d].delete();
        end
    endtask

    task automatic drive();
        int unsigned dd, cc;
        for (int d = 0; d < ND; d++) begin
            for (int c = 0; c < NUM_CHAN; c++) begin
                if (hs[d][c]) begin
                    seq[d][c]++;
                    pkt_left[d][c]--;
                    if (pkt_left[d][c] == 0) begin
                        pkt_left[d][c] = one_beat ? 1 : $urandom_range(1, 4);
                    end
                    src_valid[d][c] = 1'b0;
                end
                if (!src_valid[d][c] && ($urandom_range(0, 99) < p_valid)) begin
                    src_valid[d][c] = 1'b1;
                end
                src_tdata[d][c*DATA_WIDTH +: DATA_WIDTH] = {8'(c), 24'(seq[d][c])};
                src_last[d][c] = (pkt_left[d][c] == 1);
            end
            if (stall_left[d] != 0) begin
                mready[d] = 1'b0;
                stall_left[d]--;
            end else if ($urandom_range(0, 999) < p_stall) begin
                mready[d]     = 1'b0;
                stall_left[d] = 9;
            end else begin
                mready[d] = ($urandom_range(0, 99) < p_ready);
            end
        end
        if ($urandom_range(0, 999) < p_cfg) begin
            dd = $urandom_range(0, ND - 1);
            cc = $urandom_range(0, NUM_CHAN - 1);
            cfg_weight[dd][cc*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'($urandom_range(0, 5));
            cfg_enable[dd][cc] = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_dut(input int unsigned d);
        logic [NUM_CHAN-1:0] eg, er;
        beat_t b;
        eg = m_busy[d] ? (NUM_CHAN'(1) << m_g[d]) : '0;
        er = (m_busy[d] && (!m_ov[d] || mready[d])) ? eg : '0;
        check_eq($sformatf("d%0d arb_grant", d), 64'(o_grant[d]), 64'(eg));
        check_eq($sformatf("d%0d arb_busy", d), 64'(o_busy[d]), 64'(m_busy[d]));
        check_eq($sformatf("d%0d s_tready", d), 64'(o_sready[d]), 64'(er));
        check_eq($sformatf("d%0d m_tvalid", d), 64'(o_mvalid[d]), 64'(m_ov[d]));
        if (m_ov[d] && exp_q[d].size() != 0) begin
            b = exp_q[d][0];
            check_eq($sformatf("d%0d m_tdata", d), 64'(o_mdata[d]), 64'(b.data));
            check_eq($sformatf("d%0d m_tlast", d), 64'(o_mlast[d]), 64'(b.last));
            check_eq($sformatf("d%0d m_tuser", d), 64'(o_muser[d]), 64'(b.user));
        end
    endtask

    // Advance the model across the coming rising edge.
    task automatic model_step(input int unsigned d);
        logic [NUM_CHAN-1:0]     req;
        logic [WEIGHT_WIDTH-1:0] w;
        bit                      pre_ov, acc, tl;
        int unsigned             g, c;
        beat_t                   b;
        tl     = (d == 0);
        pre_ov = m_ov[d];
        g      = m_g[d];
        acc    = m_busy[d] && src_valid[d][g] && (!pre_ov || mready[d]);
        if (pre_ov && mready[d]) begin
            if (rec_on && d == 0) rec_user.push_back(32'(o_muser[0]));
            if (exp_q[d].size() != 0) exp_q[d].delete(0);
            m_ov[d] = 1'b0;
        end
        if (acc) begin
            b.data = src_tdata[d][g*DATA_WIDTH +: DATA_WIDTH];
            b.last = tl && src_last[d][g];
            b.user = CW'(g);
            exp_q[d].push_back(b);
            m_ov[d] = 1'b1;
            if (!tl || src_last[d][g]) m_left[d]--;
        end
        if (m_busy[d]) begin
            if (m_left[d] == 0 || (!tl && !src_valid[d][g])) begin
                m_busy[d] = 1'b0;
                m_ptr[d]  = g;
            end
        end else begin
            req = src_valid[d] & cfg_enable[d];
            if (req != '0) begin
                for (int k = 1; k <= NUM_CHAN; k++) begin
                    c = (m_ptr[d] + k) % NUM_CHAN;
                    if (req[c]) begin
                        m_g[d] = c;
                        break;
                    end
                end
                w = cfg_weight[d][m_g[d]*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                if (w == '0) m_left[d] = 1;
                else m_left[d] = 32'(w);
                m_busy[d] = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge axis_clk);
        drive();
        #1;
        for (int d = 0; d < ND; d++) begin
            check_dut(d);
            hs[d] = src_valid[d] & o_sready[d];
            model_step(d);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit found;
        n_checks = 0;
        n_errors = 0;
        rec_on   = 1'b0;
        one_beat = 1'b1;
        p_valid  = 100;
        p_ready  = 100;
        p_stall  = 0;
        p_cfg    = 0;
        for (int d = 0; d < ND; d++) begin
            cfg_enable[d] = '1;
            for (int c = 0; c < NUM_CHAN; c++) begin
                cfg_weight[d][c*WEIGHT_WIDTH +: WEIGHT_WIDTH] = WEIGHT_WIDTH'(1);
                seq[d][c] = 0;
            end
        end
        init_sources();
        reset_model();
        axis_rstn = 1'b1;
        #2 axis_rstn = 1'b0;

        repeat (3) @(negedge axis_clk);
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d reset grant", d), 64'(o_grant[d]), 64'd0);
            check_eq($sformatf("d%0d reset busy", d), 64'(o_busy[d]), 64'd0);
            check_eq($sformatf("d%0d reset m_tvalid", d), 64'(o_mvalid[d]), 64'd0);
            check_eq($sformatf("d%0d reset s_tready", d), 64'(o_sready[d]), 64'd0);
            check_eq($sformatf("d%0d reset m_tdata", d), 64'(o_mdata[d]), 64'd0);
            check_eq($sformatf("d%0d reset m_tuser", d), 64'(o_muser[d]), 64'd0);
        end
        @(posedge axis_clk);
        #2 axis_rstn = 1'b1;

        // Everyone valid, weight 1, single-beat packets: plain rotation.
        rec_on = 1'b1;
        repeat (30) cycle();
        rec_on = 1'b0;
        check_eq("rr enough beats", 64'(rec_user.size() >= 7), 64'd1);
        for (int i = 0; i < 7 && i < rec_user.size(); i++) begin
            check_eq($sformatf("rr tuser %0d", i), 64'(rec_user[i]), 64'(i % NUM_CHAN));
        end

        // Random traffic, backpressure bursts, live config changes.
        one_beat = 1'b0;
        p_valid  = 70;
        p_ready  = 75;
        p_stall  = 5;
        p_cfg    = 20;
        repeat (20000) cycle();

        // Asynchronous reset in the middle of a grant.
        for (int i = 0; i < 200 && !o_busy[0]; i++) cycle();
        check_eq("busy before reset", 64'(o_busy[0]), 64'd1);
        @(posedge axis_clk);
        #2 axis_rstn = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            check_eq($sformatf("d%0d async m_tvalid", d), 64'(o_mvalid[d]), 64'd0);
            check_eq($sformatf("d%0d async grant", d), 64'(o_grant[d]), 64'd0);
            check_eq($sformatf("d%0d async s_tready", d), 64'(o_sready[d]), 64'd0);
        end
        init_sources();
        reset_model();
        p_valid = 100;
        p_ready = 100;
        p_stall = 0;
        p_cfg   = 0;
        for (int d = 0; d < ND; d++) cfg_enable[d] = '1;
        repeat (2) @(posedge axis_clk);
        #2 axis_rstn = 1'b1;

        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cycle();
            if (o_grant[0] != '0) begin
                found = 1'b1;
                check_eq("post-reset first grant", 64'(o_grant[0]), 64'd1);
            end
        end
        check_eq("post-reset grant seen", 64'(found), 64'd1);
        repeat (50) cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
